// File: rtl/memory_loader.sv
// ---------------------------------------------------------------------------
// memory_loader
//
// Purpose:
//   Streams a program image into memoryReg's write port. Bytes arrive over a
//   valid/ready handshake. Each group of 4 bytes is packed little-endian into
//   one 32-bit word. Words go to consecutive word addresses, starting at a base
//   address that is latched when the load starts. The CPU is held (cpuHold)
//   while the load runs. A running checksum of the written words is kept.
//
// Handshake:
//   A byte transfers on a rising edge where byteValid and byteReady are both
//   high. byteReady does not depend on byteValid. The producer must hold
//   byteIn stable while byteValid is high and the byte has not yet been taken.
//
// Ports:
//   clk              in   clock, rising edge
//   reset_n          in   asynchronous active-low reset
//   start            in   begin a load (sampled in IDLE only)
//   baseAddress      in   first word address, latched on start
//   wordCount        in   number of words to load, latched on start
//   byteIn           in   stream byte
//   byteValid        in   byteIn valid
//   byteReady        out  loader accepts a byte this cycle
//   addressWrite     out  memoryReg write address (qualified by writeEnableWrite)
//   dataInWrite      out  memoryReg write data    (qualified by writeEnableWrite)
//   writeEnableWrite out  memoryReg write enable
//   busy             out  load in progress
//   cpuHold          out  same as busy; stalls fetch/PC logic
//   done             out  one-cycle pulse at the end of a load
//   checksum         out  sum of all written words, mod 2^width
//   stateDebug       out  current FSM state (IDLE=0, RECV=1, WRITE=2, DONE=3)
//
// The width parameter must be 32, which gives 4 bytes per word.
// ---------------------------------------------------------------------------
module memory_loader #(
  parameter int addresswidth = 32,
  parameter int width        = 32,
  parameter int countwidth   = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [addresswidth-1:0] baseAddress,
  input  logic [countwidth-1:0]   wordCount,
  input  logic [7:0]              byteIn,
  input  logic                    byteValid,
  output logic                    byteReady,
  output logic [addresswidth-1:0] addressWrite,
  output logic [width-1:0]        dataInWrite,
  output logic                    writeEnableWrite,
  output logic                    busy,
  output logic                    cpuHold,
  output logic                    done,
  output logic [width-1:0]        checksum,
  output logic [1:0]              stateDebug
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state;
  logic [addresswidth-1:0] addrReg;    // address of the next word to write
  logic [countwidth-1:0]   remaining;  // words still to be written
  logic [1:0]              byteIndex;  // next byte lane within the word
  logic [width-9:0]        partial;    // lower three bytes of the word being built

  // addressWrite/dataInWrite are loaded only on the edge that enters WRITE.
  // That keeps them stable outside WRITE, even though addrReg advances at the
  // end of each WRITE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      addrReg      <= '0;
      remaining    <= '0;
      byteIndex    <= 2'd0;
      partial      <= '0;
      addressWrite <= '0;
      dataInWrite  <= '0;
      checksum     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addrReg   <= baseAddress;
            remaining <= wordCount;
            checksum  <= '0;
            byteIndex <= 2'd0;
            state     <= (wordCount == '0) ? DONE : RECV;
          end
        end

        RECV: begin
          // byteReady is high for the whole of RECV, so byteValid alone
          // qualifies the transfer.
          if (byteValid) begin
            byteIndex <= byteIndex + 2'd1;
            case (byteIndex)
              2'd0: partial[7:0]   <= byteIn;
              2'd1: partial[15:8]  <= byteIn;
              2'd2: partial[23:16] <= byteIn;
              default: begin
                // The fourth byte goes straight into the write-data register.
                dataInWrite  <= {byteIn, partial};
                addressWrite <= addrReg;
                state        <= WRITE;
              end
            endcase
          end
        end

        WRITE: begin
          checksum  <= checksum + dataInWrite;
          addrReg   <= addrReg + 1'b1;
          remaining <= remaining - 1'b1;
          byteIndex <= 2'd0;
          state     <= (remaining == countwidth'(1)) ? DONE : RECV;
        end

        default: begin  // DONE
          state <= IDLE;
        end
      endcase
    end
  end

  // Control outputs are decoded from the state register only.
  assign byteReady        = (state == RECV);
  assign writeEnableWrite = (state == WRITE);
  assign busy             = (state == RECV) || (state == WRITE);
  assign cpuHold          = busy;
  assign done             = (state == DONE);
  assign stateDebug       = state;

endmodule
